// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: types and constants shared by the bit-serial subtractor.
//   state_t    - FSM state encoding (IDLE/RUN/DONE, 2 bits)
//   WIDTH_DEF  - default operand/result width
//   cnt_width  - bit-counter width for a given operand width
//   SAT_POS/SAT_NEG - saturation patterns, left-justified in 64 bits; the user
//                     shifts them down to its own width (WIDTH <= 64).
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH_DEF = 16;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

   localparam logic [63:0] SAT_POS = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] SAT_NEG = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit full subtractor cell, d = a - b - bin.
//   a, b  - operand bits
//   bin   - borrow in
//   d     - difference bit
//   bout  - borrow out
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b - bin,
// one bit per clock, LSB first, through a single full_subtractor cell.
// Optional saturation on signed overflow: macro SERIAL_SUB_SAT_EN.
//   clk, rst_n           - clock, async active-low reset
//   in_valid/in_ready    - operand handshake (a, b, bin)
//   out_valid/out_ready  - result handshake (diff, bout, ovf)
//   diff                 - a - b - bin modulo 2^WIDTH (or saturated)
//   bout                 - 1 iff unsigned a < b + bin
//   ovf                  - signed two's-complement overflow
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | processing bit cnt each clock
// DONE  | result presented, waiting for out_ready
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = cnt_width(WIDTH);
   localparam int MSB = WIDTH - 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-2:0] sh;
   logic [CW-1:0]    cnt;
   logic             br;

   logic             d_bit;
   logic             br_next;
   logic [WIDTH-1:0] raw_diff;
   logic             ovf_next;
   logic [WIDTH-1:0] diff_next;

   full_subtractor u_fs (
      .a    (a_reg[cnt]),
      .b    (b_reg[cnt]),
      .bin  (br),
      .d    (d_bit),
      .bout (br_next)
   );

   // New bit enters at the MSB; after the last bit this is the full result.
   assign raw_diff = {d_bit, sh};
   assign ovf_next = (a_reg[MSB] != b_reg[MSB]) & (raw_diff[MSB] != a_reg[MSB]);

`ifdef SERIAL_SUB_SAT_EN
   localparam logic [WIDTH-1:0] SAT_POS_W = WIDTH'(SAT_POS >> (64 - WIDTH));
   localparam logic [WIDTH-1:0] SAT_NEG_W = WIDTH'(SAT_NEG >> (64 - WIDTH));

   // Overflow direction follows the minuend sign.
   assign diff_next = ovf_next ? (a_reg[MSB] ? SAT_NEG_W : SAT_POS_W) : raw_diff;
`else
   assign diff_next = raw_diff;
`endif

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sh        <= '0;
         cnt       <= '0;
         br        <= 1'b0;
         out_valid <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= b;
                  br    <= bin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sh <= raw_diff[WIDTH-1:1];
               br <= br_next;
               if (cnt == LAST) begin
                  cnt       <= '0;
                  diff      <= diff_next;
                  bout      <= br_next;
                  ovf       <= ovf_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor (WIDTH=16).
module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        bout;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf)
   );

   // Reference: 17-bit unsigned subtraction gives borrow in bit 16.
   function automatic logic [16:0] ref_sub(input logic [15:0] av, input logic [15:0] bv, input logic bi);
      return {1'b0, av} - {1'b0, bv} - {16'b0, bi};
   endfunction

   function automatic logic ref_ovf(input logic [15:0] av, input logic [15:0] bv, input logic bi);
      logic [16:0] r;
      r = ref_sub(av, bv, bi);
      return (av[15] != bv[15]) && (r[15] != av[15]);
   endfunction

   function automatic logic [15:0] ref_diff(input logic [15:0] av, input logic [15:0] bv, input logic bi);
      logic [16:0] r;
      r = ref_sub(av, bv, bi);
`ifdef SERIAL_SUB_SAT_EN
      if (ref_ovf(av, bv, bi)) return av[15] ? 16'h8000 : 16'h7FFF;
`endif
      return r[15:0];
   endfunction

   // Runs one operation. lat counts the accept cycle as 1, so out_valid first
   // seen after the WIDTH-th bit edge gives WIDTH+1.
   task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                         input int stall, output logic [15:0] d, output logic bo,
                         output logic ov, output int lat, output bit tmo);
      int n;
      tmo = 1'b0;
      lat = 0;
      d   = '0;
      bo  = 1'b0;
      ov  = 1'b0;
      n   = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         tmo = 1'b1;
         return;
      end
      a         = av;
      b         = bv;
      bin       = bi;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) begin
         tmo = 1'b1;
         out_ready = 1'b1;
         return;
      end
      d  = diff;
      bo = bout;
      ov = ovf;
      if (stall > 0) begin
         repeat (stall) begin
            @(posedge clk); #1;
         end
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      out_ready = 1'b1;
      #12;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
      end
      checks++;
      if (diff !== 16'h0000 || bout !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_out diff=%h bout=%b ovf=%b exp 0000/0/0", diff, bout, ovf);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [15:0] d;
      logic bo, ov;
      int lat;
      bit tmo;
      run_op(16'h0005, 16'h0003, 1'b0, 0, d, bo, ov, lat, tmo);
      checks++;
      if (tmo !== 1'b0) begin
         errors++;
         $display("FAIL basic_timeout got timeout exp result");
      end
      checks++;
      if (d !== 16'h0002 || bo !== 1'b0 || ov !== 1'b0) begin
         errors++;
         $display("FAIL basic_result diff=%h bout=%b ovf=%b exp 0002/0/0", d, bo, ov);
      end
      checks++;
      if (lat !== 17) begin
         errors++;
         $display("FAIL basic_latency got %0d exp 17", lat);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_ready_after got %b exp 1", in_ready);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] d;
      logic bo, ov;
      int lat;
      bit tmo;
      run_op(16'h0000, 16'h0001, 1'b0, 0, d, bo, ov, lat, tmo);
      checks++;
      if (tmo || d !== 16'hFFFF || bo !== 1'b1 || ov !== 1'b0) begin
         errors++;
         $display("FAIL wrap_0m1 tmo=%b diff=%h bout=%b ovf=%b exp FFFF/1/0", tmo, d, bo, ov);
      end
      run_op(16'h1234, 16'h1234, 1'b1, 0, d, bo, ov, lat, tmo);
      checks++;
      if (tmo || d !== 16'hFFFF || bo !== 1'b1 || ov !== 1'b0) begin
         errors++;
         $display("FAIL wrap_bin tmo=%b diff=%h bout=%b ovf=%b exp FFFF/1/0", tmo, d, bo, ov);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] d;
      logic bo, ov;
      logic [15:0] exp_d;
      int lat;
      bit tmo;
`ifdef SERIAL_SUB_SAT_EN
      exp_d = 16'h8000;
`else
      exp_d = 16'h7FFF;
`endif
      run_op(16'h8000, 16'h0001, 1'b0, 0, d, bo, ov, lat, tmo);
      checks++;
      if (tmo || d !== exp_d || bo !== 1'b0 || ov !== 1'b1) begin
         errors++;
         $display("FAIL ovf_neg tmo=%b diff=%h bout=%b ovf=%b exp %h/0/1", tmo, d, bo, ov, exp_d);
      end
`ifdef SERIAL_SUB_SAT_EN
      exp_d = 16'h7FFF;
`else
      exp_d = 16'h8000;
`endif
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, d, bo, ov, lat, tmo);
      checks++;
      if (tmo || d !== exp_d || bo !== 1'b1 || ov !== 1'b1) begin
         errors++;
         $display("FAIL ovf_pos tmo=%b diff=%h bout=%b ovf=%b exp %h/1/1", tmo, d, bo, ov, exp_d);
      end
   endtask

   task automatic test_backpressure();
      int n;
      a         = 16'h00F0;
      b         = 16'h000F;
      bin       = 1'b1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      a        = 16'hFFFF;
      b        = 16'h0000;
      bin      = 1'b0;
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_run_ready got %b exp 0", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (out_valid !== 1'b1 || diff !== 16'h00E0 || bout !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL bp_result out_valid=%b diff=%h bout=%b ovf=%b exp 1/00E0/0/0",
                  out_valid, diff, bout, ovf);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || diff !== 16'h00E0 || bout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d out_valid=%b diff=%h bout=%b ovf=%b in_ready=%b exp 1/00E0/0/0/0",
                     i, out_valid, diff, bout, ovf, in_ready);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
      end
      checks++;
      if (diff !== 16'h00E0) begin
         errors++;
         $display("FAIL bp_diff_kept got %h exp 00E0", diff);
      end
      // The pulse during RUN must not have started a second operation.
      repeat (3) begin
         @(posedge clk); #1;
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_no_ghost in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] d;
      logic bo, ov;
      int lat;
      bit tmo;
      a         = 16'h7FFF;
      b         = 16'hFFFF;
      bin       = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || diff !== 16'h0000 || bout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid out_valid=%b diff=%h bout=%b ovf=%b in_ready=%b exp 0/0000/0/0/1",
                  out_valid, diff, bout, ovf, in_ready);
      end
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'h0010, 16'h0001, 1'b0, 0, d, bo, ov, lat, tmo);
      checks++;
      if (tmo || d !== 16'h000F || bo !== 1'b0 || ov !== 1'b0 || lat !== 17) begin
         errors++;
         $display("FAIL rst_after tmo=%b diff=%h bout=%b ovf=%b lat=%0d exp 000F/0/0/17",
                  tmo, d, bo, ov, lat);
      end
   endtask

   task automatic test_random();
      logic [15:0] av, bv, d;
      logic bi, bo, ov;
      logic [16:0] r;
      int lat, stall;
      bit tmo;
      for (int i = 0; i < 1000; i++) begin
         av    = 16'($urandom);
         bv    = 16'($urandom);
         bi    = 1'($urandom);
         stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         run_op(av, bv, bi, stall, d, bo, ov, lat, tmo);
         r = ref_sub(av, bv, bi);
         checks++;
         if (tmo || d !== ref_diff(av, bv, bi)) begin
            errors++;
            $display("FAIL rnd_diff %h-%h-%b tmo=%b got %h exp %h", av, bv, bi, tmo, d, ref_diff(av, bv, bi));
         end
         checks++;
         if (bo !== r[16]) begin
            errors++;
            $display("FAIL rnd_bout %h-%h-%b got %b exp %b", av, bv, bi, bo, r[16]);
         end
         checks++;
         if (ov !== ref_ovf(av, bv, bi)) begin
            errors++;
            $display("FAIL rnd_ovf %h-%h-%b got %b exp %b", av, bv, bi, ov, ref_ovf(av, bv, bi));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_overflow();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
